regfile_write_arbiter: RTL

//  Sole driver of the register file write port (A3/WE3/WD3).

---
 rtl/regfile_pkg.sv | 12 +
 rtl/sync_fifo.sv | 75 +++++++
 rtl/regfile_write_arbiter.sv | 110 +++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file widths and the writeback request record used by both producers.
package regfile_pkg;

    localparam int DATA_WIDTH    = 32;
    localparam int ADDRESS_WIDTH = 5;

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0]    data;
    } wb_req_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO for long-latency writeback results.
// Besides the usual push/pop interface it exposes which slots hold live entries
// and their destination registers, so the owner can build a pending mask.
module sync_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  wb_req_t                  i_data,
    output wb_req_t                  o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [DEPTH-1:0]         o_entryValid,
    output logic [ADDRESS_WIDTH-1:0] o_entryRd [DEPTH]
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    wb_req_t         r_mem [DEPTH];
    logic [PW-1:0]   r_wrPtr;
    logic [PW-1:0]   r_rdPtr;
    logic [CW-1:0]   r_count;
    logic            w_doPush;
    logic            w_doPop;

    assign o_full   = (r_count == CW'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign w_doPush = i_push & ~o_full;
    assign w_doPop  = i_pop & ~o_empty;
    assign o_head   = r_mem[r_rdPtr];

    // Payload storage; contents need no reset because validity is tracked by the count.
    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            if (w_doPush && !w_doPop) begin
                r_count <= r_count + 1'b1;
            end else if (w_doPop && !w_doPush) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // A slot is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            logic [PW-1:0] offset;
            offset          = PW'(i) - r_rdPtr;
            o_entryValid[i] = (CW'(offset) < r_count);
            o_entryRd[i]    = r_mem[i].rd;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Sole driver of the register-file write port. The in-order pipeline normally
// wins; long-latency results wait in a FIFO and force one write through once the
// head has waited STARVE_LIMIT cycles. The pending mask lets decode stall on
// registers still owed by the long-latency unit.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        p_valid,
    output logic                        p_ready,
    input  logic [ADDRESS_WIDTH-1:0]    p_rd,
    input  logic [DATA_WIDTH-1:0]       p_data,
    input  logic                        l_valid,
    output logic                        l_ready,
    input  logic [ADDRESS_WIDTH-1:0]    l_rd,
    input  logic [DATA_WIDTH-1:0]       l_data,
    output logic                        WE3,
    output logic [ADDRESS_WIDTH-1:0]    A3,
    output logic [DATA_WIDTH-1:0]       WD3,
    output logic [2**ADDRESS_WIDTH-1:0] pending
);

    localparam int SW   = $clog2(STARVE_LIMIT + 1);
    localparam int NREG = 2**ADDRESS_WIDTH;

    logic [SW-1:0]            r_starveCnt;
    wb_req_t                  w_head;
    wb_req_t                  w_lReq;
    logic                     w_full;
    logic                     w_empty;
    logic [FIFO_DEPTH-1:0]    w_entryValid;
    logic [ADDRESS_WIDTH-1:0] w_entryRd [FIFO_DEPTH];
    logic                     w_stallP;
    logic                     w_pWin;
    logic                     w_pop;
    logic                     w_push;
    logic [NREG-1:0]          w_pending;

    assign w_lReq.rd   = l_rd;
    assign w_lReq.data = l_data;

    // The FIFO is only ever "full" on registered state, so a pop never frees a
    // slot for a push in the same cycle.
    assign w_stallP = ~w_empty & (r_starveCnt == SW'(STARVE_LIMIT));
    assign p_ready  = ~rst & ~w_stallP;
    assign l_ready  = ~rst & ~w_full;
    assign w_push   = l_valid & l_ready;
    assign w_pWin   = p_valid & p_ready;
    assign w_pop    = ~rst & ~w_pWin & ~w_empty;

    sync_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .i_push       (w_push),
        .i_pop        (w_pop),
        .i_data       (w_lReq),
        .o_head       (w_head),
        .o_full       (w_full),
        .o_empty      (w_empty),
        .o_entryValid (w_entryValid),
        .o_entryRd    (w_entryRd)
    );

    // Write-port mux: pipeline first, else FIFO head; x0 writes still consume their slot.
    always_comb begin
        WE3 = 1'b0;
        A3  = '0;
        WD3 = '0;
        if (w_pWin) begin
            WE3 = (p_rd != '0);
            A3  = p_rd;
            WD3 = p_data;
        end else if (w_pop) begin
            WE3 = (w_head.rd != '0);
            A3  = w_head.rd;
            WD3 = w_head.data;
        end
    end

    // Counts how long the FIFO head has been passed over; saturates at the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starveCnt <= '0;
        end else if (w_empty || w_pop) begin
            r_starveCnt <= '0;
        end else if (r_starveCnt != SW'(STARVE_LIMIT)) begin
            r_starveCnt <= r_starveCnt + 1'b1;
        end
    end

    // Pending mask is the OR of one-hot destinations of live FIFO entries; x0 never pends.
    always_comb begin
        w_pending = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (w_entryValid[i]) begin
                w_pending[w_entryRd[i]] = 1'b1;
            end
        end
        w_pending[0] = 1'b0;
    end

    assign pending = rst ? '0 : w_pending;

endmodule
